// File: rtl/axi_defs.sv
// Shared AXI read-channel definitions and refill-arbiter helpers.
package axi_defs;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ID_W       = 4;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned SIZE_W     = 3;
  localparam int unsigned BURST_W    = 2;
  localparam int unsigned RESP_W     = 2;
  localparam int unsigned LINE_OFF_W = 5;

  localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
  localparam logic [SIZE_W-1:0]  SIZE_4B    = 3'b010;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_e;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } ar_payload_t;

  // Two-way round-robin pick; on a tie the requester not granted last time wins.
  function automatic req_e rr_pick(input logic ic_req, input logic dc_req, input req_e last_grant);
    req_e win;
    win = REQ_IC;
    if (ic_req && dc_req) begin
      win = (last_grant == REQ_IC) ? REQ_DC : REQ_IC;
    end else if (dc_req) begin
      win = REQ_DC;
    end
    return win;
  endfunction

  // Clear the line-offset bits so the burst starts on a 32-byte boundary.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:LINE_OFF_W], LINE_OFF_W'(0)};
  endfunction

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// AXI read address/data channel bundle between the refill arbiter and memory.
interface cache_refill_arbiter_if;
  import axi_defs::*;

  logic [ID_W-1:0]    arid;
  logic [ADDR_W-1:0]  araddr;
  logic [LEN_W-1:0]   arlen;
  logic [SIZE_W-1:0]  arsize;
  logic [BURST_W-1:0] arburst;
  logic               arvalid;
  logic               arready;

  logic [ID_W-1:0]    rid;
  logic [DATA_W-1:0]  rdata;
  logic [RESP_W-1:0]  rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/cache_refill_arbiter.sv
// Shares one AXI read channel between icache and dcache line refills,
// one 8-beat INCR burst at a time, round-robin between the two caches.
module cache_refill_arbiter
  import axi_defs::*;
#(
  parameter int unsigned     LINE_BEATS = 8,
  parameter logic [ID_W-1:0] IC_ID      = 4'd0,
  parameter logic [ID_W-1:0] DC_ID      = 4'd1
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   ic_req,
  input  logic [ADDR_W-1:0]      ic_addr,
  input  logic                   ic_flush,
  output logic [DATA_W-1:0]      ic_rdata,
  output logic                   ic_rvalid,
  output logic                   ic_rlast,

  input  logic                   dc_req,
  input  logic [ADDR_W-1:0]      dc_addr,
  output logic [DATA_W-1:0]      dc_rdata,
  output logic                   dc_rvalid,
  output logic                   dc_rlast,

  cache_refill_arbiter_if.master axi
);

  localparam int unsigned      CNT_W    = 3;
  localparam logic [LEN_W-1:0] LINE_LEN = LEN_W'(LINE_BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_BEATS - 1);

  arb_state_e       state_q, state_d;
  req_e             grant_q, grant_d;
  req_e             last_grant_q, last_grant_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  ar_payload_t      ar_q, ar_d;
  logic             arvalid_q, rready_q;

  logic             ar_hs;
  logic             beat_acc;
  logic             ic_flush_hit;
  logic             unused_axi;

  assign ar_hs        = (state_q == ARB_ADDR) && arvalid_q && axi.arready;
  assign beat_acc     = (state_q == ARB_DATA) && axi.rvalid;
  assign ic_flush_hit = ic_flush && (grant_q == REQ_IC);

  // Response status and returned id are deliberately not inspected.
  assign unused_axi = ^{axi.rid, axi.rresp};

  // Next-state, grant, AR payload and flush-drop bookkeeping.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    drop_d       = drop_q;
    beat_cnt_d   = beat_cnt_q;
    ar_d         = ar_q;

    case (state_q)
      ARB_IDLE: begin
        if (ic_req || dc_req) begin
          grant_d      = rr_pick(ic_req, dc_req, last_grant_q);
          last_grant_d = grant_d;
          ar_d.id      = (grant_d == REQ_IC) ? IC_ID : DC_ID;
          ar_d.addr    = line_align((grant_d == REQ_IC) ? ic_addr : dc_addr);
          ar_d.len     = LINE_LEN;
          ar_d.size    = SIZE_4B;
          ar_d.burst   = BURST_INCR;
          beat_cnt_d   = '0;
          drop_d       = 1'b0;
          state_d      = ARB_ADDR;
        end
      end

      ARB_ADDR: begin
        if (ic_flush_hit) begin
          drop_d = 1'b1;
        end
        if (ar_hs) begin
          state_d = ARB_DATA;
        end
      end

      ARB_DATA: begin
        if (ic_flush_hit) begin
          drop_d = 1'b1;
        end
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (axi.rlast) begin
            state_d = ARB_IDLE;
            drop_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers; AR valid and R ready follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      grant_q      <= REQ_IC;
      last_grant_q <= REQ_DC;
      drop_q       <= 1'b0;
      beat_cnt_q   <= '0;
      ar_q         <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
      beat_cnt_q   <= beat_cnt_d;
      ar_q         <= ar_d;
      arvalid_q    <= (state_d == ARB_ADDR);
      rready_q     <= (state_d == ARB_DATA);
    end
  end

  assign axi.arid    = ar_q.id;
  assign axi.araddr  = ar_q.addr;
  assign axi.arlen   = ar_q.len;
  assign axi.arsize  = ar_q.size;
  assign axi.arburst = ar_q.burst;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  // Zero-latency beat steering to the granted cache; flushed icache beats are hidden.
  always_comb begin
    ic_rdata  = '0;
    ic_rvalid = 1'b0;
    ic_rlast  = 1'b0;
    dc_rdata  = '0;
    dc_rvalid = 1'b0;
    dc_rlast  = 1'b0;

    if (!reset && (state_q == ARB_DATA)) begin
      if (grant_q == REQ_IC) begin
        ic_rdata  = axi.rdata;
        ic_rvalid = axi.rvalid && !drop_q && !ic_flush;
        ic_rlast  = axi.rvalid && axi.rlast && !drop_q && !ic_flush;
      end else begin
        dc_rdata  = axi.rdata;
        dc_rvalid = axi.rvalid;
        dc_rlast  = axi.rvalid && axi.rlast;
      end
    end
  end

  // A well-formed slave ends every burst exactly on the last line beat.
  a_rlast_on_last_beat: assert property (
    @(posedge clk) disable iff (reset)
    (beat_acc && axi.rlast) |-> (beat_cnt_q == LAST_CNT)
  );

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: vector table plus corner-case sequences.
module tb_cache_refill_arbiter;
  import axi_defs::*;

  logic        clk;
  logic        reset;
  logic        ic_req, ic_flush, dc_req;
  logic [31:0] ic_addr, dc_addr;
  logic [31:0] ic_rdata, dc_rdata;
  logic        ic_rvalid, ic_rlast, dc_rvalid, dc_rlast;

  int n_cmp = 0;
  int n_bad = 0;

  cache_refill_arbiter_if axi_bus ();

  cache_refill_arbiter #(
    .LINE_BEATS (8),
    .IC_ID      (4'd0),
    .DC_ID      (4'd1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_flush  (ic_flush),
    .ic_rdata  (ic_rdata),
    .ic_rvalid (ic_rvalid),
    .ic_rlast  (ic_rlast),
    .dc_req    (dc_req),
    .dc_addr   (dc_addr),
    .dc_rdata  (dc_rdata),
    .dc_rvalid (dc_rvalid),
    .dc_rlast  (dc_rlast),
    .axi       (axi_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        ir, fl, ar, rv, rl;
    logic [31:0] d;
    logic        ea, er, eiv, eil;
    logic [31:0] eaa;
    logic [31:0] e_ic_rdata;
  } vec_t;

  vec_t tbl[$];

  // inp = {ic_req, ic_flush, arready, rvalid, rlast}; exp = {arvalid, rready, ic_rvalid, ic_rlast}
  function automatic vec_t mk(input logic [31:0] addr, input logic [4:0] inp,
                              input logic [31:0] d, input logic [3:0] exp,
                              input logic [31:0] eaa);
    vec_t v;
    v.addr = addr;
    {v.ir, v.fl, v.ar, v.rv, v.rl} = inp;
    v.d = d;
    {v.ea, v.er, v.eiv, v.eil} = exp;
    v.eaa = eaa;
    v.e_ic_rdata = v.er ? d : 32'h0;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk1 ({tag, ".arvalid"},   axi_bus.arvalid, 1'b0);
    chk1 ({tag, ".rready"},    axi_bus.rready,  1'b0);
    chk32({tag, ".araddr"},    axi_bus.araddr,  32'h0);
    chk32({tag, ".arid"},      32'(axi_bus.arid),    32'h0);
    chk32({tag, ".arlen"},     32'(axi_bus.arlen),   32'h0);
    chk32({tag, ".arsize"},    32'(axi_bus.arsize),  32'h0);
    chk32({tag, ".arburst"},   32'(axi_bus.arburst), 32'h0);
    chk1 ({tag, ".ic_rvalid"}, ic_rvalid, 1'b0);
    chk1 ({tag, ".ic_rlast"},  ic_rlast,  1'b0);
    chk32({tag, ".ic_rdata"},  ic_rdata,  32'h0);
    chk1 ({tag, ".dc_rvalid"}, dc_rvalid, 1'b0);
    chk1 ({tag, ".dc_rlast"},  dc_rlast,  1'b0);
    chk32({tag, ".dc_rdata"},  dc_rdata,  32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0; ic_flush = 1'b0;
    ic_addr = 32'h0; dc_addr = 32'h0;
    axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.rlast = 1'b0;
    axi_bus.rdata = 32'h0; axi_bus.rid = 4'h0; axi_bus.rresp = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Bounded wait for arvalid, sampled mid-cycle.
  task automatic wait_arvalid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = axi_bus.arvalid;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s.arvalid_timeout: got arvalid=0 for 20 cycles, want 1", tag);
    end
  endtask

  // Feed 8 beats after the AR handshake cycle, then check the return to IDLE.
  task automatic drain(input bit to_ic, input logic [31:0] base, input string tag);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      axi_bus.arready = 1'b0;
      axi_bus.rvalid  = 1'b1;
      axi_bus.rlast   = (k == 8);
      axi_bus.rdata   = base + 32'(k);
      #1;
      chk1($sformatf("%s.b%0d.rready", tag, k), axi_bus.rready, 1'b1);
      chk1($sformatf("%s.b%0d.ic_rvalid", tag, k), ic_rvalid, to_ic);
      chk1($sformatf("%s.b%0d.dc_rvalid", tag, k), dc_rvalid, !to_ic);
      chk32($sformatf("%s.b%0d.rdata", tag, k), to_ic ? ic_rdata : dc_rdata, base + 32'(k));
      chk1($sformatf("%s.b%0d.rlast", tag, k), to_ic ? ic_rlast : dc_rlast, (k == 8));
    end
    @(negedge clk);
    axi_bus.rvalid = 1'b0;
    axi_bus.rlast  = 1'b0;
    axi_bus.rdata  = 32'h0;
    #1;
    chk1({tag, ".idle.rready"},  axi_bus.rready,  1'b0);
    chk1({tag, ".idle.arvalid"}, axi_bus.arvalid, 1'b0);
  endtask

  task automatic burst(input logic [3:0] eid, input bit to_ic, input logic [31:0] base, input string tag);
    wait_arvalid(tag);
    chk32({tag, ".arid"}, 32'(axi_bus.arid), 32'(eid));
    axi_bus.arready = 1'b1;
    drain(to_ic, base, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0; ic_flush = 1'b0;
    ic_addr = 32'h0; dc_addr = 32'h0;
    axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.rlast = 1'b0;
    axi_bus.rdata = 32'h0; axi_bus.rid = 4'h0; axi_bus.rresp = 2'b00;

    // Reset state
    do_reset();
    #1;
    all_zero("reset");

    // Vector table: single icache burst, then a back-to-back flushed burst with a gap
    tbl.push_back(mk(32'hBFC0_0014, 5'b1_0_0_0_0, 32'h0, 4'b0_0_0_0, 32'h0));
    tbl.push_back(mk(32'hBFC0_0014, 5'b1_0_1_0_0, 32'h0, 4'b1_0_0_0, 32'hBFC0_0000));
    for (int k = 1; k <= 8; k++) begin
      tbl.push_back(mk(32'hBFC0_0014, {1'b1, 1'b0, 1'b0, 1'b1, (k == 8)}, 32'(32'h11 * k),
                       {1'b0, 1'b1, 1'b1, (k == 8)}, 32'h0));
    end
    tbl.push_back(mk(32'h0000_1234, 5'b1_0_0_0_0, 32'h0, 4'b0_0_0_0, 32'h0));
    tbl.push_back(mk(32'h0000_1234, 5'b1_0_1_0_0, 32'h0, 4'b1_0_0_0, 32'h0000_1220));
    for (int k = 1; k <= 8; k++) begin
      if (k == 6) begin
        tbl.push_back(mk(32'h0000_1234, 5'b1_0_0_0_0, 32'h0, 4'b0_1_0_0, 32'h0));
      end
      tbl.push_back(mk(32'h0000_1234, {1'b1, (k == 3), 1'b0, 1'b1, (k == 8)}, 32'hC0DE_0000 + 32'(k),
                       {1'b0, 1'b1, (k < 3), 1'b0}, 32'h0));
    end
    tbl.push_back(mk(32'h0000_1234, 5'b0_1_0_0_0, 32'h0, 4'b0_0_0_0, 32'h0));
    tbl.push_back(mk(32'h0000_1234, 5'b0_0_0_0_0, 32'h0, 4'b0_0_0_0, 32'h0));

    foreach (tbl[i]) begin
      @(negedge clk);
      ic_addr         = tbl[i].addr;
      ic_req          = tbl[i].ir;
      ic_flush        = tbl[i].fl;
      axi_bus.arready = tbl[i].ar;
      axi_bus.rvalid  = tbl[i].rv;
      axi_bus.rlast   = tbl[i].rl;
      axi_bus.rdata   = tbl[i].d;
      #1;
      chk1 ($sformatf("v%0d.arvalid", i),   axi_bus.arvalid, tbl[i].ea);
      chk1 ($sformatf("v%0d.rready", i),    axi_bus.rready,  tbl[i].er);
      chk1 ($sformatf("v%0d.ic_rvalid", i), ic_rvalid,       tbl[i].eiv);
      chk1 ($sformatf("v%0d.ic_rlast", i),  ic_rlast,        tbl[i].eil);
      chk32($sformatf("v%0d.ic_rdata", i),  ic_rdata,        tbl[i].e_ic_rdata);
      chk1 ($sformatf("v%0d.dc_rvalid", i), dc_rvalid,       1'b0);
      chk32($sformatf("v%0d.dc_rdata", i),  dc_rdata,        32'h0);
      if (tbl[i].ea) begin
        chk32($sformatf("v%0d.araddr", i),  axi_bus.araddr,        tbl[i].eaa);
        chk32($sformatf("v%0d.arid", i),    32'(axi_bus.arid),    32'h0);
        chk32($sformatf("v%0d.arlen", i),   32'(axi_bus.arlen),   32'd7);
        chk32($sformatf("v%0d.arsize", i),  32'(axi_bus.arsize),  32'd2);
        chk32($sformatf("v%0d.arburst", i), 32'(axi_bus.arburst), 32'd1);
      end
    end

    // Simultaneous requests from reset: IC, DC, then IC again
    do_reset();
    ic_addr = 32'h0000_4000;
    dc_addr = 32'h0000_8000;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    burst(4'd0, 1'b1, 32'hA100_0000, "rr1");
    burst(4'd1, 1'b0, 32'hA200_0000, "rr2");
    burst(4'd0, 1'b1, 32'hA300_0000, "rr3");
    ic_req = 1'b0;
    dc_req = 1'b0;

    // arready held off for 5 cycles; early rvalid must not be forwarded
    do_reset();
    ic_addr        = 32'h8000_0044;
    ic_req         = 1'b1;
    axi_bus.rvalid = 1'b1;
    axi_bus.rdata  = 32'hDEAD_BEEF;
    axi_bus.rresp  = 2'b10;
    #1;
    chk1("dly.idle.arvalid", axi_bus.arvalid, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      axi_bus.arready = (i == 5);
      #1;
      chk1 ($sformatf("dly.c%0d.arvalid", i),   axi_bus.arvalid, 1'b1);
      chk32($sformatf("dly.c%0d.araddr", i),    axi_bus.araddr,  32'h8000_0040);
      chk32($sformatf("dly.c%0d.arid", i),      32'(axi_bus.arid), 32'h0);
      chk1 ($sformatf("dly.c%0d.rready", i),    axi_bus.rready,  1'b0);
      chk1 ($sformatf("dly.c%0d.ic_rvalid", i), ic_rvalid,       1'b0);
      chk32($sformatf("dly.c%0d.ic_rdata", i),  ic_rdata,        32'h0);
    end
    drain(1'b1, 32'h7700_0000, "dly");
    ic_req = 1'b0;

    // Reset at beat 4 of a dcache burst; icache flush during it is ignored
    do_reset();
    dc_addr = 32'h1000_0008;
    dc_req  = 1'b1;
    wait_arvalid("rst");
    chk32("rst.arid",   32'(axi_bus.arid), 32'd1);
    chk32("rst.araddr", axi_bus.araddr,    32'h1000_0000);
    axi_bus.arready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      axi_bus.arready = 1'b0;
      axi_bus.rvalid  = 1'b1;
      axi_bus.rlast   = 1'b0;
      axi_bus.rdata   = 32'h5500_0000 + 32'(k);
      ic_flush        = (k == 2);
      if (k == 4) begin
        reset  = 1'b1;
        dc_req = 1'b0;
      end
      #1;
      if (k < 4) begin
        chk1($sformatf("rst.b%0d.dc_rvalid", k), dc_rvalid, 1'b1);
        chk32($sformatf("rst.b%0d.dc_rdata", k), dc_rdata, 32'h5500_0000 + 32'(k));
      end
    end
    @(negedge clk);
    reset          = 1'b0;
    ic_flush       = 1'b0;
    axi_bus.rvalid = 1'b1;
    axi_bus.rdata  = 32'hFFFF_FFFF;
    ic_addr        = 32'h2000_003C;
    ic_req         = 1'b1;
    #1;
    all_zero("rst.after");
    chk32("rst.state", 32'(dut.state_q), 32'(ARB_IDLE));
    @(negedge clk);
    axi_bus.rvalid = 1'b0;
    axi_bus.rdata  = 32'h0;
    #1;
    chk1 ("rst.next.arvalid", axi_bus.arvalid, 1'b1);
    chk32("rst.next.arid",    32'(axi_bus.arid), 32'h0);
    chk32("rst.next.araddr",  axi_bus.araddr,  32'h2000_0020);
    axi_bus.arready = 1'b1;
    drain(1'b1, 32'h6600_0000, "rst.ic");
    ic_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_refill_arbiter.md
# cache_refill_arbiter

Shares the single AXI read address/data channel between the instruction-cache and data-cache refill engines. It grants one requester at a time using round-robin. For the granted requester it issues one aligned 8-beat INCR burst (one 32-byte line) and returns the R beats to it as a `rdata`/`rvalid` pair, which is the refill interface the caches already consume. It sits between the two caches and the core's AXI master port.

## Interface
Parameters:
- `LINE_BEATS`, default 8: beats per refill burst. `arlen = LINE_BEATS-1`.
- `IC_ID`, default 4'd0: `arid` used for instruction-cache bursts.
- `DC_ID`, default 4'd1: `arid` used for data-cache bursts.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: reset is synchronous and active-high.
- `ic_req` in 1: icache refill request. Level; held until `ic_rlast` is delivered.
- `ic_addr` in 32: icache miss address. Sampled at grant.
- `ic_flush` in 1: icache pipeline flush. Discards the remaining icache beats.
- `ic_rdata` out 32: beat data to the icache.
- `ic_rvalid` out 1: beat valid to the icache.
- `ic_rlast` out 1: last beat to the icache.
- `dc_req`, `dc_addr`, `dc_rdata`, `dc_rvalid`, `dc_rlast`: same meanings for the dcache. There is no flush input on this side.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1: AXI read address channel.
- `arready` in 1: AXI read address ready.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1: AXI read data channel.
- `rready` out 1: AXI read data ready.

## Operation
- FSM states:
  - `IDLE`: no burst outstanding.
  - `ADDR`: `arvalid` high, waiting for `arready`.
  - `DATA`: draining R beats.
- Arbitration happens in `IDLE` only.
  - If exactly one request is high, that requester wins.
  - If both are high, the requester not in `last_grant` wins.
  - `last_grant` resets to DC, so icache wins the first tie.
- On grant:
  - Latch the grant and set `last_grant`.
  - Latch `{addr[31:5],5'b0}` as `araddr`.
  - `arid` is `IC_ID` or `DC_ID`; `arlen = 7`; `arsize = 3'b010`; `arburst = 2'b01`.
  - Go to `ADDR`.
- `ADDR`:
  - `arvalid` is high and all AR fields are held stable until `arready`.
  - On `arvalid && arready`, go to `DATA`.
- `DATA`:
  - `rready` is held at 1.
  - Each `rvalid` beat is forwarded combinationally to the granted requester. Its `*_rvalid` and `*_rlast` copy `rvalid` and `rlast`; `*_rdata = rdata`.
  - The other requester's outputs are 0.
  - On `rvalid && rlast`, go to `IDLE`.
  - A 3-bit beat counter counts accepted beats. `rlast` is the only end condition.
  - `rresp` is ignored. `rid` is not checked.
- Flush (icache grant only):
  - `ic_flush` in `ADDR` or `DATA` sets a `drop` flag. A flush with `rvalid` high suppresses that same beat.
  - While `drop` is set, `ic_rvalid` and `ic_rlast` are forced to 0.
  - `arvalid` is never withdrawn once asserted; the burst is still fully drained.
  - `drop` clears on the return to `IDLE`.
  - `ic_flush` in `IDLE`, or during a dcache grant, has no effect.
- A requester dropping `*_req` mid-burst does not abort the burst.
- Reset, including mid-burst:
  - Synchronous; wins over all other events.
  - State returns to `IDLE`; `drop` clears; counter is 0; `last_grant` is DC.
  - Reset value of every output is 0 (AR fields, `arvalid`, `rready`, all `*_rvalid`/`*_rlast`/`*_rdata`).

## Timing
- Request to address: `*_req` high in `IDLE` at cycle N gives registered `arvalid` at cycle N+1.
- AR handshake at cycle M puts the FSM in `DATA` at M+1, with `rready = 1` from M+1.
- Beat latency to the cache is 0 cycles (combinational pass-through of `rdata`/`rvalid`/`rlast`).
- `rlast` accepted at cycle L gives `IDLE` at L+1. The earliest next `arvalid` is L+2.
- Only one burst is outstanding at a time.
- Gaps in `rvalid` are tolerated; nothing advances without `rvalid`.

## Structure
- Shared package `axi_defs`:
  - AXI burst/size constants (`BURST_INCR`, `SIZE_4B`).
  - State encodings `ARB_IDLE`, `ARB_ADDR`, `ARB_DATA`.
  - Requester IDs.
- No sub-module; one flat module.
- A reusable two-way round-robin picker `rr_arb2` may be factored out if the dcache write path needs the same picker.

## Test plan
- Single icache request:
  - Stimulus: `ic_addr = 0xBFC0_0014`, `arready = 1`, 8 beats `0x11..0x88`.
  - Required: `araddr = 0xBFC0_0000`, `arid = 0`, `arlen = 7`.
  - Required: `ic_rvalid` for 8 beats with matching data and `ic_rlast` on beat 8; `dc_rvalid` stays 0.
- Simultaneous requests from reset:
  - Stimulus: both requests high; let both bursts complete.
  - Required: icache served first, then dcache (`arid = 1`).
  - Then raise both again; required: icache served first again (alternation).
- `arready` delayed 5 cycles:
  - Required: `arvalid` held high with `araddr` and `arid` constant for 6 cycles.
  - Required: no beats forwarded before the handshake.
- `ic_flush` asserted at beat 3:
  - Required: beats 1-2 delivered; beats 3-8 produce no `ic_rvalid` and no `ic_rlast`.
  - Required: `rready` stays 1 throughout; `IDLE` on the cycle after `rlast`.
- `reset` asserted at beat 4 of a dcache burst:
  - Required: the next cycle all outputs are 0 and the FSM is in `IDLE`.
  - Required: with a new `ic_req`, `arvalid` rises 1 cycle later.
